ex_operand_stage: RTL

ID/EX pipeline register and operand-forwarding stage that feeds the ALU. It latches the decoded instruction each cycle and drives the ALU operands `op1`/`op2` and the 4-bit `AluFun` from register values, the PC, or the immediate. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It detects load-use hazards and raises a stall to IF/ID while inserting a bubble.

---
 rtl/ex_operand_if.sv | 37 +++
 rtl/ex_operand_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ex_operand_if.sv
// ID -> EX issue bundle: decoded instruction from ID,
// stall back to IF/ID.
interface ex_operand_if #(
  parameter int WIDTH = 32
);
  logic             id_valid;
  logic [WIDTH-1:0] id_pc;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic [WIDTH-1:0] id_rs1_val;
  logic [WIDTH-1:0] id_rs2_val;
  logic [WIDTH-1:0] id_imm;
  logic [3:0]       id_alufun;
  logic [1:0]       id_op1_sel;
  logic [1:0]       id_op2_sel;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             stall;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd,
    output id_rs1_val, id_rs2_val, id_imm, id_alufun,
    output id_op1_sel, id_op2_sel,
    output id_reg_write, id_mem_read, id_mem_write,
    input  stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd,
    input  id_rs1_val, id_rs2_val, id_imm, id_alufun,
    input  id_op1_sel, id_op2_sel,
    input  id_reg_write, id_mem_read, id_mem_write,
    output stall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX register with RAW forwarding, ALU operand muxing
// and load-use stall generation.
module ex_operand_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  ex_operand_if.slave      id,
  input  logic             flush,
  input  logic             ex_hold,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_reg_write,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_reg_write,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [3:0]       AluFun,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             ex_valid,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [WIDTH-1:0] ex_pc
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [WIDTH-1:0] imm;
    logic [3:0]       alufun;
    logic [1:0]       op1_sel;
    logic [1:0]       op2_sel;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d_in;
  logic   load_use;

  logic [WIDTH-1:0] fwd_rs1;
  logic [WIDTH-1:0] fwd_rs2;
  logic [WIDTH-1:0] four;

  assign four = WIDTH'(4);

  always_comb begin
    d_in           = '0;
    d_in.valid     = id.id_valid;
    d_in.pc        = id.id_pc;
    d_in.rs1       = id.id_rs1;
    d_in.rs2       = id.id_rs2;
    d_in.rd        = id.id_rd;
    d_in.rs1_val   = id.id_rs1_val;
    d_in.rs2_val   = id.id_rs2_val;
    d_in.imm       = id.id_imm;
    d_in.alufun    = id.id_alufun;
    d_in.op1_sel   = id.id_op1_sel;
    d_in.op2_sel   = id.id_op2_sel;
    d_in.reg_write = id.id_reg_write;
    d_in.mem_read  = id.id_mem_read;
    d_in.mem_write = id.id_mem_write;
  end

  assign load_use = q.valid & q.mem_read
                  & (q.rd != 5'd0) & id.id_valid
                  & ((q.rd == id.id_rs1)
                   | (q.rd == id.id_rs2));

  // flush kills both a pending load-use and a hold
  assign id.stall = ~reset & ~flush
                  & (ex_hold | load_use);

  always_ff @(posedge clk) begin
    if (reset)         q <= '0;
    else if (flush)    q <= '0;
    else if (ex_hold)  q <= q;
    else if (load_use) q <= '0;
    else               q <= d_in;
  end

  function automatic logic [WIDTH-1:0] fwd(
    input logic [4:0]       r,
    input logic [WIDTH-1:0] v
  );
    if (exmem_reg_write && exmem_rd == r && r != 5'd0)
      return exmem_result;
    else if (memwb_reg_write && memwb_rd == r && r != 5'd0)
      return memwb_result;
    else
      return v;
  endfunction

  assign fwd_rs1 = fwd(q.rs1, q.rs1_val);
  assign fwd_rs2 = fwd(q.rs2, q.rs2_val);

  always_comb begin
    op1 = '0;
    op2 = '0;
    AluFun = 4'd0;
    ex_store_data = '0;
    if (q.valid) begin
      AluFun = q.alufun;
      ex_store_data = fwd_rs2;
      case (q.op1_sel)
        2'b00:   op1 = fwd_rs1;
        2'b01:   op1 = q.pc;
        2'b10:   op1 = '0;
        default: op1 = q.imm;
      endcase
      case (q.op2_sel)
        2'b00:   op2 = fwd_rs2;
        2'b01:   op2 = q.imm;
        2'b10:   op2 = four;
        default: op2 = '0;
      endcase
    end
  end

  assign ex_valid     = q.valid;
  assign ex_rd        = q.valid ? q.rd : 5'd0;
  assign ex_reg_write = q.valid & q.reg_write;
  assign ex_mem_read  = q.valid & q.mem_read;
  assign ex_mem_write = q.valid & q.mem_write;
  assign ex_pc        = q.valid ? q.pc : '0;

endmodule
